pa_dtu_dbginfo_ctrl: RTL and testbench



---
 rtl/pa_dtu_dbginfo_ctrl_pkg.sv | 37 +++
 rtl/pa_dtu_dbginfo_ctrl.sv | 146 ++++++++++++++
 tb/tb_pa_dtu_dbginfo_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pa_dtu_dbginfo_ctrl_pkg.sv
// Shared constants and types for the DTU debug-info capture/readout controller.
// CSR map, snapshot geometry, FSM encodings and the status CSR layout.
package pa_dtu_dbginfo_ctrl_pkg;

  localparam int          DBG_NUM_WORDS = 11;
  localparam int          DBG_PTR_W     = 4;

  localparam logic [11:0] DBG_ADDR_STAT = 12'hfe0;
  localparam logic [11:0] DBG_ADDR_DATA = 12'hfe1;
  localparam logic [11:0] DBG_ADDR_CTRL = 12'hfe2;

  localparam int          CTRL_CLR_BIT    = 0;
  localparam int          CTRL_REARM_BIT  = 1;
  localparam int          CTRL_CONT_BIT   = 2;
  localparam int          CTRL_CNTCLR_BIT = 3;

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_HELD = 2'd1;
  localparam logic [1:0]  ST_READ = 2'd2;

  // Field order here is the bit order software sees in the status CSR (MSB first).
  typedef struct packed {
    logic [14:0] pad;
    logic        cont;
    logic [7:0]  cap_cnt;
    logic [3:0]  ptr;
    logic        last_src;
    logic        rearm;
    logic        ovf;
    logic        valid;
  } dbg_status_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pa_dtu_dbginfo_ctrl.sv
// Capture-and-readout controller for the DTU debug-info snapshot: arbitrates
// halt/breakpoint capture, freezes the snapshot, and sequences CSR readout.
module pa_dtu_dbginfo_ctrl
  import pa_dtu_dbginfo_ctrl_pkg::*;
#(
  parameter int          NUM_WORDS = DBG_NUM_WORDS,
  parameter int          PTR_W     = DBG_PTR_W,
  parameter logic [11:0] ADDR_STAT = DBG_ADDR_STAT,
  parameter logic [11:0] ADDR_DATA = DBG_ADDR_DATA,
  parameter logic [11:0] ADDR_CTRL = DBG_ADDR_CTRL
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             dtu_rtu_async_halt_req,
  input  logic             had_dtu_bkpt_trig,
  input  logic             cp0_dtu_rreg,
  input  logic             cp0_dtu_wreg,
  input  logic [11:0]      cp0_dtu_addr,
  input  logic [31:0]      cp0_dtu_wdata,
  input  logic [27:0]      dbginfo_rd_word,
  output logic             dbginfo_cap_en,
  output logic [PTR_W-1:0] dbginfo_rd_ptr,
  output logic [31:0]      dbgfifo_regs_data
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WORDS - 1);

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_valid;
  logic             r_ovf;
  logic [7:0]       r_cap_cnt;
  logic             r_last_src;
  logic             r_rearm;
  logic             r_cont;

  logic             w_trig;
  logic             w_src;
  logic             w_wr_ctrl;
  logic             w_clr;
  logic             w_rd;
  logic             w_rd_data;
  logic             w_rd_stat;
  logic             w_wrap;
  logic             w_cap;
  logic             w_ovf_set;
  logic [1:0]       w_state_nxt;
  logic             w_valid_nxt;
  dbg_status_t      w_status;
  logic             w_unused_ok;

  assign w_trig    = dtu_rtu_async_halt_req | had_dtu_bkpt_trig;
  assign w_src     = ~dtu_rtu_async_halt_req;
  assign w_wr_ctrl = cp0_dtu_wreg & (cp0_dtu_addr == ADDR_CTRL);
  assign w_clr     = w_wr_ctrl & cp0_dtu_wdata[CTRL_CLR_BIT];
  // A write strobe masks any read strobe in the same cycle.
  assign w_rd      = cp0_dtu_rreg & ~cp0_dtu_wreg;
  assign w_rd_data = w_rd & (cp0_dtu_addr == ADDR_DATA);
  assign w_rd_stat = w_rd & (cp0_dtu_addr == ADDR_STAT);
  assign w_wrap    = (r_ptr == LAST_PTR);
  assign w_cap     = cpurst_b & w_trig & ((r_state == ST_IDLE) | r_cont) & ~w_clr;
  assign w_ovf_set = w_trig & ~r_cont & ~w_clr & (r_state != ST_IDLE);

  assign dbginfo_cap_en = w_cap;
  assign dbginfo_rd_ptr = r_ptr;
  assign w_unused_ok    = ^cp0_dtu_wdata[31:4];

  // Readout moves first, then a capture re-validates, and clr overrides both.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    if (w_rd_data) begin
      case (r_state)
        ST_IDLE: ;
        ST_HELD: w_state_nxt = ST_READ;
        ST_READ: begin
          if (w_wrap) begin
            if (r_rearm) begin
              w_state_nxt = ST_IDLE;
              w_valid_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_HELD;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_cap) begin
      w_valid_nxt = 1'b1;
      if (w_state_nxt == ST_IDLE) w_state_nxt = ST_HELD;
    end
    if (w_clr) begin
      w_state_nxt = ST_IDLE;
      w_valid_nxt = 1'b0;
    end
  end

  always_comb begin
    w_status          = '0;
    w_status.cont     = r_cont;
    w_status.cap_cnt  = r_cap_cnt;
    w_status.ptr      = 4'(r_ptr);
    w_status.last_src = r_last_src;
    w_status.rearm    = r_rearm;
    w_status.ovf      = r_ovf;
    w_status.valid    = r_valid;
    dbgfifo_regs_data = 32'h0;
    if (w_rd_stat)      dbgfifo_regs_data = w_status;
    else if (w_rd_data) dbgfifo_regs_data = {dbginfo_rd_word, 4'(r_ptr)};
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_cap_cnt  <= 8'h0;
      r_last_src <= 1'b0;
      r_rearm    <= 1'b0;
      r_cont     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;

      if (w_clr)          r_ptr <= '0;
      else if (w_rd_data) r_ptr <= w_wrap ? '0 : r_ptr + PTR_W'(1);

      if (w_clr)          r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;

      if (w_cap) r_last_src <= w_src;

      // Counter clear wins over a coincident capture increment.
      if (w_wr_ctrl && cp0_dtu_wdata[CTRL_CNTCLR_BIT]) r_cap_cnt <= 8'h0;
      else if (w_cap)                                   r_cap_cnt <= sat_inc8(r_cap_cnt);

      if (w_wr_ctrl) begin
        r_rearm <= cp0_dtu_wdata[CTRL_REARM_BIT];
        r_cont  <= cp0_dtu_wdata[CTRL_CONT_BIT];
      end
    end
  end

endmodule

// File: tb/tb_pa_dtu_dbginfo_ctrl.sv
// Self-checking bench for pa_dtu_dbginfo_ctrl: directed scenarios plus random
// traffic, all compared against a behavioural model of the capture/readout rules.
module tb_pa_dtu_dbginfo_ctrl;

  localparam int NW = 11;
  localparam logic [11:0] A_STAT = 12'hfe0;
  localparam logic [11:0] A_DATA = 12'hfe1;
  localparam logic [11:0] A_CTRL = 12'hfe2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halt, bkpt, rreg, wreg;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [27:0] rd_word;
  logic        cap_en;
  logic [3:0]  rd_ptr;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  pa_dtu_dbginfo_ctrl dut (
    .forever_cpuclk         (clk),
    .cpurst_b               (rst_b),
    .dtu_rtu_async_halt_req (halt),
    .had_dtu_bkpt_trig      (bkpt),
    .cp0_dtu_rreg           (rreg),
    .cp0_dtu_wreg           (wreg),
    .cp0_dtu_addr           (addr),
    .cp0_dtu_wdata          (wdata),
    .dbginfo_rd_word        (rd_word),
    .dbginfo_cap_en         (cap_en),
    .dbginfo_rd_ptr         (rd_ptr),
    .dbgfifo_regs_data      (rdata)
  );

  // Snapshot storage stand-in: reloads random content whenever the DUT captures.
  logic [27:0] mem [NW];
  assign rd_word = (int'(rd_ptr) < NW) ? mem[rd_ptr] : 28'h0;
  always @(posedge clk) begin
    if (cap_en) begin
      for (int i = 0; i < NW; i++) mem[i] <= 28'($urandom);
    end
  end

  typedef enum {M_IDLE, M_HELD, M_READ} mstate_t;
  mstate_t m_state;
  int      m_ptr, m_cnt;
  bit      m_valid, m_ovf, m_src, m_rearm, m_cont;

  int          checks = 0;
  int          failures = 0;
  logic        exp_cap, obs_cap;
  logic [31:0] exp_data, obs_data;
  int          exp_ptr, obs_ptr;

  function automatic logic [31:0] m_status();
    return (32'(m_cont) << 16) | (32'(m_cnt) << 8) | (32'(m_ptr) << 4) |
           (32'(m_src) << 3) | (32'(m_rearm) << 2) | (32'(m_ovf) << 1) | 32'(m_valid);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_ptr = 0; m_cnt = 0;
    m_valid = 0; m_ovf = 0; m_src = 0; m_rearm = 0; m_cont = 0;
  endtask

  // One clock of stimulus: predicts outputs, samples the DUT mid-cycle, then advances the model.
  task automatic applyStimulus(input logic h, input logic b, input logic r, input logic w,
                               input logic [11:0] a, input logic [31:0] d);
    bit clr, trig, rd;
    halt = h; bkpt = b; rreg = r; wreg = w; addr = a; wdata = d;
    #3;
    clr  = w && (a == A_CTRL) && d[0];
    trig = h || b;
    rd   = r && !w;
    exp_cap  = trig && (m_state == M_IDLE || m_cont) && !clr;
    exp_ptr  = m_ptr;
    exp_data = 32'h0;
    if (rd && a == A_STAT)      exp_data = m_status();
    else if (rd && a == A_DATA) exp_data = {mem[m_ptr], 4'(m_ptr)};
    obs_cap = cap_en; obs_data = rdata; obs_ptr = int'(rd_ptr);
    @(posedge clk);
    if (rd && a == A_DATA) begin
      if (m_state == M_HELD) m_state = M_READ;
      else if (m_state == M_READ && m_ptr == NW - 1) begin
        if (m_rearm) begin m_state = M_IDLE; m_valid = 0; end
        else m_state = M_HELD;
      end
      m_ptr = (m_ptr == NW - 1) ? 0 : m_ptr + 1;
    end
    if (exp_cap) begin
      m_valid = 1; m_src = h ? 0 : 1;
      if (m_cnt < 255) m_cnt++;
      if (m_state == M_IDLE) m_state = M_HELD;
    end else if (trig && !clr) begin
      m_ovf = 1;
    end
    if (w && a == A_CTRL) begin
      m_rearm = d[1]; m_cont = d[2];
      if (d[3]) m_cnt = 0;
      if (d[0]) begin m_state = M_IDLE; m_ptr = 0; m_valid = 0; m_ovf = 0; end
    end
    #1;
    halt = 0; bkpt = 0; rreg = 0; wreg = 0;
  endtask

  task automatic do_reset();
    rst_b = 0; halt = 1; bkpt = 1; rreg = 1; wreg = 0; addr = A_DATA; wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1; halt = 0; bkpt = 0; rreg = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_status got=%h exp=00000000", obs_data); end
    checks++; if (obs_cap !== 1'b0) begin failures++; $display("[TB] FAIL reset_cap_en got=%b exp=0", obs_cap); end
    checks++; if (obs_ptr !== 0) begin failures++; $display("[TB] FAIL reset_ptr got=%0d exp=0", obs_ptr); end
    applyStimulus(0, 0, 0, 0, A_STAT, 0);
    checks++; if (obs_data !== 32'h0) begin failures++; $display("[TB] FAIL idle_rdata got=%h exp=00000000", obs_data); end
  endtask

  task automatic test_capture();
    applyStimulus(1, 0, 0, 0, 12'h0, 0);
    checks++; if (obs_cap !== 1'b1) begin failures++; $display("[TB] FAIL capture_cap_en got=%b exp=1", obs_cap); end
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== 32'h0000_0101) begin failures++; $display("[TB] FAIL capture_status got=%h exp=00000101", obs_data); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 12'h0, 0);
      checks++; if (obs_cap !== 1'b0) begin failures++; $display("[TB] FAIL ovf_cap_en%0d got=%b exp=0", i, obs_cap); end
    end
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== 32'h0000_0103) begin failures++; $display("[TB] FAIL ovf_status got=%h exp=00000103", obs_data); end
    applyStimulus(0, 0, 0, 1, A_CTRL, 32'h1);
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== 32'h0000_0100) begin failures++; $display("[TB] FAIL clr_status got=%h exp=00000100", obs_data); end
  endtask

  task automatic test_readout_rearm();
    applyStimulus(0, 0, 0, 1, A_CTRL, 32'h3);
    applyStimulus(1, 0, 0, 0, 12'h0, 0);
    for (int i = 0; i < NW; i++) begin
      applyStimulus(0, 0, 1, 0, A_DATA, 0);
      checks++; if (obs_data !== exp_data || obs_data[3:0] !== 4'(i)) begin
        failures++; $display("[TB] FAIL rearm_read%0d got=%h exp=%h", i, obs_data, exp_data); end
    end
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== exp_data || obs_data[0] !== 1'b0) begin
      failures++; $display("[TB] FAIL rearm_status got=%h exp=%h", obs_data, exp_data); end
    applyStimulus(0, 1, 0, 0, 12'h0, 0);
    checks++; if (obs_cap !== 1'b1) begin failures++; $display("[TB] FAIL rearm_recapture got=%b exp=1", obs_cap); end
  endtask

  task automatic test_readout_hold();
    applyStimulus(0, 0, 0, 1, A_CTRL, 32'h0);
    for (int i = 0; i < NW; i++) begin
      applyStimulus(0, 0, 1, 0, A_DATA, 0);
      checks++; if (obs_data !== exp_data) begin failures++; $display("[TB] FAIL hold_read%0d got=%h exp=%h", i, obs_data, exp_data); end
    end
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== exp_data || obs_data[7:4] !== 4'h0 || obs_data[0] !== 1'b1) begin
      failures++; $display("[TB] FAIL hold_status got=%h exp=%h", obs_data, exp_data); end
    applyStimulus(0, 0, 1, 0, A_DATA, 0);
    checks++; if (obs_data !== exp_data || obs_data[3:0] !== 4'h0) begin
      failures++; $display("[TB] FAIL hold_read12 got=%h exp=%h", obs_data, exp_data); end
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== exp_data || obs_data[7:4] !== 4'h1) begin
      failures++; $display("[TB] FAIL hold_ptr1 got=%h exp=%h", obs_data, exp_data); end
  endtask

  task automatic test_clr_vs_trig();
    int cnt_before;
    cnt_before = m_cnt;
    applyStimulus(1, 0, 0, 1, A_CTRL, 32'h1);
    checks++; if (obs_cap !== 1'b0) begin failures++; $display("[TB] FAIL clrtrig_cap_en got=%b exp=0", obs_cap); end
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== exp_data || int'(obs_data[15:8]) != cnt_before || obs_data[1:0] !== 2'b00) begin
      failures++; $display("[TB] FAIL clrtrig_status got=%h exp=%h", obs_data, exp_data); end
  endtask

  task automatic test_reset_mid_read();
    applyStimulus(0, 1, 0, 0, 12'h0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, A_DATA, 0);
    applyStimulus(0, 0, 0, 0, 12'h0, 0);
    checks++; if (obs_ptr !== 5) begin failures++; $display("[TB] FAIL midread_ptr got=%0d exp=5", obs_ptr); end
    rst_b = 0; rreg = 1; addr = A_DATA; halt = 1;
    @(posedge clk);
    #1;
    rst_b = 1; rreg = 0; halt = 0;
    model_reset();
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== 32'h0 || obs_ptr !== 0) begin
      failures++; $display("[TB] FAIL midread_reset got=%h ptr=%0d exp=00000000 ptr=0", obs_data, obs_ptr); end
  endtask

  task automatic test_cont_saturate();
    int miss;
    miss = 0;
    applyStimulus(0, 0, 0, 1, A_CTRL, 32'hC);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 1'b1, 0, 0, 12'h0, 0);
      checks++; if (obs_cap !== 1'b1) begin failures++; miss++;
        if (miss < 4) $display("[TB] FAIL cont_cap_en%0d got=%b exp=1", i, obs_cap); end
    end
    applyStimulus(1, 1, 0, 0, 12'h0, 0);
    applyStimulus(0, 0, 1, 0, A_STAT, 0);
    checks++; if (obs_data !== exp_data || obs_data[15:8] !== 8'hff || obs_data[1] !== 1'b0 || obs_data[3] !== 1'b0) begin
      failures++; $display("[TB] FAIL cont_status got=%h exp=%h", obs_data, exp_data); end
  endtask

  task automatic test_random();
    int op, bad;
    logic [31:0] d;
    bad = 0;
    applyStimulus(0, 0, 0, 1, A_CTRL, 32'h9);
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 9);
      d  = $urandom & 32'hffff_fffe;
      if ($urandom_range(0, 3) == 0) d[0] = 1'b1;
      case (op)
        0, 1, 2, 3: applyStimulus(($urandom_range(0,3)==0), ($urandom_range(0,3)==0), 1, 0, A_DATA, 0);
        4:          applyStimulus(($urandom_range(0,3)==0), ($urandom_range(0,3)==0), 1, 0, A_STAT, 0);
        5:          applyStimulus(($urandom_range(0,3)==0), ($urandom_range(0,3)==0), 0, 1, A_CTRL, d);
        6:          applyStimulus(($urandom_range(0,3)==0), 0, 1, 0, 12'(($urandom_range(0,15)==0) ? 12'hfe3 : 12'($urandom)), 0);
        7:          applyStimulus(0, ($urandom_range(0,1)==0), 1, 1, ($urandom_range(0,1)==0) ? A_DATA : A_CTRL, d & 32'hffff_fffe);
        default:    applyStimulus(($urandom_range(0,3)==0), ($urandom_range(0,3)==0), 0, 0, 12'h0, 0);
      endcase
      checks++; if (obs_cap !== exp_cap || obs_data !== exp_data || obs_ptr !== exp_ptr) begin
        failures++; bad++;
        if (bad < 6) $display("[TB] FAIL random%0d cap=%b/%b data=%h/%h ptr=%0d/%0d (got/exp)",
                              i, obs_cap, exp_cap, obs_data, exp_data, obs_ptr, exp_ptr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 28'($urandom);
    rst_b = 0; halt = 0; bkpt = 0; rreg = 0; wreg = 0; addr = 0; wdata = 0;
    model_reset();
    test_reset();
    test_capture();
    test_overflow();
    test_readout_rearm();
    test_readout_hold();
    test_clr_vs_trig();
    test_reset_mid_read();
    test_cont_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
